// File: rtl/next_pc_sequencer.sv
// next_pc_sequencer
//
// Produces the fetch address that feeds the PC stage. It presents that address
// to instruction memory through a valid/ready request, steps it sequentially,
// applies branch and jump redirects, buffers a redirect that arrives while a
// request is waiting, and implements halt/resume.
//
// Handshake: a fetch transfers on a rising edge where oFetchValid and
// iFetchReady are both high. While oFetchValid is high and iFetchReady is low,
// oNextPC stays stable. iStall may drop oFetchValid at any time; that is not a
// transfer.
//
// Ports
//   iClk, iRst_n        clock, asynchronous active-low reset
//   iStall              suppresses the fetch request while high
//   iHalt               level halt request
//   iResume             resume pulse, only acted on while halted
//   iBranchTaken/Target resolved taken branch (wins over a jump)
//   iJump/iJumpTarget   jump
//   iFetchReady         instruction memory accepts the request
//   oNextPC             registered fetch address
//   oFetchValid         fetch request valid
//   oHalted             high while halted
//   oRedirectPending    a buffered redirect is waiting to be applied
//   oDbgState           FSM state (0 RUN, 1 HALTED, 2 RESUME)
module next_pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] PC_STEP      = 32'd4
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iStall,
  input  logic        iHalt,
  input  logic        iResume,
  input  logic        iBranchTaken,
  input  logic [31:0] iBranchTarget,
  input  logic        iJump,
  input  logic [31:0] iJumpTarget,
  input  logic        iFetchReady,
  output logic [31:0] oNextPC,
  output logic        oFetchValid,
  output logic        oHalted,
  output logic        oRedirectPending,
  output logic [1:0]  oDbgState
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_RESUME = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;

  logic        fetch_valid;
  logic        accept;
  logic        live_redirect;
  logic [31:0] live_target;

  assign fetch_valid   = (state_q == ST_RUN) && !iStall;
  assign accept        = fetch_valid && iFetchReady;
  assign live_redirect = iBranchTaken || iJump;
  assign live_target   = iBranchTaken ? iBranchTarget : iJumpTarget;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_VECTOR;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  // PC / pending-redirect update.
  always_comb begin
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    if (live_redirect && fetch_valid && !iFetchReady) begin
      // Request is outstanding: the address must stay stable, so park the
      // target. A newer redirect simply overwrites an older parked one.
      pend_target_d = live_target;
      pend_valid_d  = 1'b1;
    end else if (live_redirect) begin
      pc_d         = live_target;
      pend_valid_d = 1'b0;
    end else if (accept && pend_valid_q) begin
      pc_d         = pend_target_q;
      pend_valid_d = 1'b0;
    end else if (accept) begin
      pc_d = pc_q + PC_STEP;  // wraps modulo 2^32
    end
  end

  // Halt/resume sequencing. RESUME is a single bubble cycle before RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:    if (iHalt) state_d = ST_HALTED;
      ST_HALTED: if (iResume && !iHalt) state_d = ST_RESUME;
      ST_RESUME: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  assign oNextPC          = pc_q;
  assign oFetchValid      = fetch_valid;
  assign oHalted          = (state_q == ST_HALTED);
  assign oRedirectPending = pend_valid_q;
  assign oDbgState        = state_q;

endmodule

// File: tb/tb_next_pc_sequencer.sv
module tb_next_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, halt = 1'b0, resume = 1'b0;
  logic        br = 1'b0, jmp = 1'b0, rdy = 1'b0;
  logic [31:0] br_t = 32'h0, jmp_t = 32'h0;
  logic [31:0] next_pc;
  logic        fetch_valid, halted, pending;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: architectural fetch address, halt mode and parked target.
  // mode 0 = fetching, 1 = halted, 2 = one-cycle resume bubble.
  logic [31:0] m_pc;
  int          m_mode;
  logic        m_pend;
  logic [31:0] m_pend_t;
  logic [31:0] exp_q[$];

  next_pc_sequencer dut (
    .iClk(clk), .iRst_n(rst_n), .iStall(stall), .iHalt(halt), .iResume(resume),
    .iBranchTaken(br), .iBranchTarget(br_t), .iJump(jmp), .iJumpTarget(jmp_t),
    .iFetchReady(rdy), .oNextPC(next_pc), .oFetchValid(fetch_valid),
    .oHalted(halted), .oRedirectPending(pending), .oDbgState(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_pc = 32'h0; m_mode = 0; m_pend = 1'b0; m_pend_t = 32'h0;
  endfunction

  // Advance the model by one clock using the inputs present before the edge.
  function automatic void model_step();
    bit          req, xfer, redir;
    logic [31:0] tgt;
    req   = (m_mode == 0) && !stall;
    xfer  = req && rdy;
    redir = br || jmp;
    tgt   = br ? br_t : jmp_t;
    if (redir && req && !rdy) begin
      m_pend = 1'b1; m_pend_t = tgt;
    end else if (redir) begin
      m_pc = tgt; m_pend = 1'b0;
    end else if (xfer && m_pend) begin
      m_pc = m_pend_t; m_pend = 1'b0;
    end else if (xfer) begin
      m_pc = m_pc + 32'd4;
    end
    if (m_mode == 0 && halt) m_mode = 1;
    else if (m_mode == 1 && resume && !halt) m_mode = 2;
    else if (m_mode == 2) m_mode = 0;
  endfunction

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; halt = 0; resume = 0; br = 0; jmp = 0; rdy = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Loads the PC through an accepted jump.
  task automatic load_pc(input logic [31:0] a);
    jmp = 1; jmp_t = a; rdy = 1;
    step();
    jmp = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    #2;
    stall = 1;
    #1;
    n_vec++;
    if (fetch_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_stall_fv got %b want 0", fetch_valid);
    end
    stall = 0;
    #1;
    n_vec++;
    if (next_pc !== 32'h0 || halted !== 1'b0 || pending !== 1'b0 ||
        fetch_valid !== 1'b1 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state got pc=%h h=%b p=%b fv=%b st=%0d want pc=0 h=0 p=0 fv=1 st=0",
               next_pc, halted, pending, fetch_valid, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rdy = 1;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_vec++;
      if (next_pc !== 32'(4 * i) || fetch_valid !== 1'b1 || halted !== 1'b0) begin
        n_err++;
        $display("FAIL seq_step%0d got pc=%h fv=%b h=%b want pc=%h fv=1 h=0",
                 i, next_pc, fetch_valid, halted, 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_pending();
    load_pc(32'h100);
    rdy = 0; br = 1; br_t = 32'h400;
    step();
    br = 0;
    n_vec++;
    if (next_pc !== 32'h100 || pending !== 1'b1) begin
      n_err++; $display("FAIL pend_hold got pc=%h p=%b want 100 1", next_pc, pending);
    end
    rdy = 1;
    step();
    n_vec++;
    if (next_pc !== 32'h400 || pending !== 1'b0) begin
      n_err++; $display("FAIL pend_apply got pc=%h p=%b want 400 0", next_pc, pending);
    end
    step();
    n_vec++;
    if (next_pc !== 32'h404) begin
      n_err++; $display("FAIL pend_after got %h want 404", next_pc);
    end
  endtask

  task automatic test_priority();
    br = 1; br_t = 32'h200; jmp = 1; jmp_t = 32'h300; rdy = 1;
    step();
    br = 0; jmp = 0;
    n_vec++;
    if (next_pc !== 32'h200) begin
      n_err++; $display("FAIL br_over_jmp got %h want 200", next_pc);
    end
  endtask

  task automatic test_wrap();
    load_pc(32'hFFFF_FFFC);
    step();
    n_vec++;
    if (next_pc !== 32'h0) begin
      n_err++; $display("FAIL wrap got %h want 0", next_pc);
    end
  endtask

  task automatic test_halt_resume();
    load_pc(32'h40);
    halt = 1; rdy = 1;
    step();
    halt = 0;
    n_vec++;
    if (next_pc !== 32'h44 || halted !== 1'b1 || fetch_valid !== 1'b0) begin
      n_err++; $display("FAIL halt_entry got pc=%h h=%b fv=%b want 44 1 0", next_pc, halted, fetch_valid);
    end
    jmp = 1; jmp_t = 32'h80;
    step();
    jmp = 0;
    n_vec++;
    if (next_pc !== 32'h80 || halted !== 1'b1) begin
      n_err++; $display("FAIL halt_jump got pc=%h h=%b want 80 1", next_pc, halted);
    end
    resume = 1;
    step();
    resume = 0;
    n_vec++;
    if (halted !== 1'b0 || fetch_valid !== 1'b0 || next_pc !== 32'h80) begin
      n_err++; $display("FAIL resume_bubble got h=%b fv=%b pc=%h want 0 0 80", halted, fetch_valid, next_pc);
    end
    step();
    n_vec++;
    if (fetch_valid !== 1'b1 || next_pc !== 32'h80) begin
      n_err++; $display("FAIL resume_run got fv=%b pc=%h want 1 80", fetch_valid, next_pc);
    end
    halt = 1;
    step();
    resume = 1;
    step();
    n_vec++;
    if (halted !== 1'b1) begin
      n_err++; $display("FAIL halt_and_resume got h=%b want 1", halted);
    end
    halt = 0;
    step();
    resume = 0;
    step();
  endtask

  task automatic test_async_reset();
    load_pc(32'h500);
    rdy = 0; jmp = 1; jmp_t = 32'h900;
    step();
    jmp = 0;
    n_vec++;
    if (pending !== 1'b1 || next_pc !== 32'h500) begin
      n_err++; $display("FAIL pre_reset got p=%b pc=%h want 1 500", pending, next_pc);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (next_pc !== 32'h0 || pending !== 1'b0 || halted !== 1'b0 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL async_reset got pc=%h p=%b h=%b st=%0d want 0 0 0 0", next_pc, pending, halted, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rdy = 1;
    step();
    n_vec++;
    if (next_pc !== 32'h4) begin
      n_err++; $display("FAIL first_edge_accept got %h want 4", next_pc);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      stall  = ($urandom_range(0, 4) == 0);
      rdy    = ($urandom_range(0, 2) != 0);
      halt   = ($urandom_range(0, 9) == 0);
      resume = ($urandom_range(0, 3) == 0);
      br     = ($urandom_range(0, 7) == 0);
      jmp    = ($urandom_range(0, 7) == 0);
      br_t   = $urandom & 32'hFFFF_FFFC;
      jmp_t  = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      #1;
      n_vec++;
      if (fetch_valid !== ((m_mode == 0) && !stall)) begin
        n_err++; $display("FAIL rand_fv cyc%0d got %b want %b", i, fetch_valid, (m_mode == 0) && !stall);
      end
      step();
      exp_q.push_back(m_pc);
      exp_pc = exp_q.pop_front();
      n_vec++;
      if (next_pc !== exp_pc || halted !== (m_mode == 1) || pending !== m_pend) begin
        n_err++;
        $display("FAIL rand_state cyc%0d got pc=%h h=%b p=%b want pc=%h h=%b p=%b",
                 i, next_pc, halted, pending, exp_pc, m_mode == 1, m_pend);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_redirect_pending();
    test_priority();
    test_wrap();
    test_halt_resume();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
